// File: rtl/obj_pkg.sv
// Object RAM entry layout, line-list entry type and scan FSM encodings.
package obj_pkg;
    localparam int NUM_OBJ = 8;
    localparam int ENTRY_W = 13;
    localparam int ON_BIT  = 12;
    localparam int TILE_HI = 11;
    localparam int TILE_LO = 9;
    localparam int X_HI    = 8;
    localparam int X_LO    = 4;
    localparam int Y_HI    = 3;
    localparam int Y_LO    = 0;
    localparam int MAX_COL = 18;
    localparam int MAX_ROW = 14;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } scanState_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] tile;
        logic [4:0] x;
    } lineEnt_t;
endpackage

// File: rtl/obj_ram_8x13.sv
// 8-entry object RAM: one synchronous write port, one asynchronous read port.
module obj_ram_8x13
    import obj_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         wrAddr,
    input  logic [ENTRY_W-1:0] wrData,
    input  logic               we,
    input  logic [2:0]         rdAddr,
    output logic [ENTRY_W-1:0] rdData
);
    logic [NUM_OBJ-1:0][ENTRY_W-1:0] mem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  mem         <= '0;
        else if (we)   mem[wrAddr] <= wrData;
    end

    assign rdData = mem[rdAddr];
endmodule

// File: rtl/obj_scan_renderer.sv
// Builds a per-line object hit list in hblank and resolves the winning object per pixel.
// Define OBJ_COLLIDE_EN to add the oCollide frame collision flag.
module obj_scan_renderer
    import obj_pkg::*;
#(
    parameter int X_ORIGIN   = 16,
    parameter int Y_ORIGIN   = 0,
    parameter int TILE_SHIFT = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         iObjRam_addr,
    input  logic [ENTRY_W-1:0] iObjRam_data,
    input  logic               iObjRam_we,
    input  logic               iVS,
    input  logic               iLine_start,
    input  logic [9:0]         iNext_y,
    input  logic               iPix_valid,
    input  logic [9:0]         iPix_x,
    output logic               oPix_valid,
    output logic               oObj_hit,
    output logic [2:0]         oTile_no,
    output logic [4:0]         oTile_px,
    output logic [4:0]         oTile_py,
    output logic               oScan_busy
`ifdef OBJ_COLLIDE_EN
    ,output logic              oCollide
`endif
);
    scanState_t state, stateNxt;
    logic [3:0] idx;
    logic [2:0] prevIdx;
    logic [9:0] row, yRow, xCol;
    logic rowOk;
    logic [4:0] py, pyActive;
    logic [10:0] yDiff, xDiff;
    logic [ENTRY_W-1:0] ramRd, rdEntry;
    lineEnt_t [NUM_OBJ-1:0] shadow, active;

    obj_ram_8x13 uRam (
        .clk(clk), .reset_n(reset_n),
        .wrAddr(iObjRam_addr), .wrData(iObjRam_data), .we(iObjRam_we),
        .rdAddr(idx[2:0]), .rdData(ramRd)
    );

    // 11-bit differences: bit 10 flags a coordinate above/left of the origin
    assign yDiff   = {1'b0, iNext_y} - 11'(Y_ORIGIN);
    assign yRow    = yDiff[9:0] >> TILE_SHIFT;
    assign prevIdx = idx[2:0] - 3'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            ST_IDLE:   stateNxt = ST_IDLE;
            ST_SCAN:   if (idx == 4'(NUM_OBJ)) stateNxt = ST_COMMIT;
            ST_COMMIT: stateNxt = ST_IDLE;
            default:   stateNxt = ST_IDLE;
        endcase
        if (iLine_start) stateNxt = ST_SCAN;
    end

    assign oScan_busy = (state != ST_IDLE);

    // RAM read is registered, so shadow[idx-1] is filled while entry idx is read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx      <= '0;
            row      <= '0;
            rowOk    <= 1'b0;
            py       <= '0;
            pyActive <= '0;
            rdEntry  <= '0;
            shadow   <= '0;
            active   <= '0;
        end else if (iLine_start) begin
            idx    <= '0;
            row    <= yRow;
            rowOk  <= !yDiff[10] && (yRow <= 10'(MAX_ROW));
            py     <= yDiff[4:0];
            shadow <= '0;
        end else if (state == ST_SCAN) begin
            rdEntry <= ramRd;
            idx     <= idx + 4'd1;
            if (idx != 4'd0) begin
                shadow[prevIdx].valid <= rdEntry[ON_BIT] && rowOk &&
                                         ({6'd0, rdEntry[Y_HI:Y_LO]} == row);
                shadow[prevIdx].tile  <= rdEntry[TILE_HI:TILE_LO];
                shadow[prevIdx].x     <= rdEntry[X_HI:X_LO];
            end
        end else if (state == ST_COMMIT) begin
            active   <= shadow;
            pyActive <= py;
        end
    end

    logic [1:0] vldPipe;
    logic [4:0] s1Col, s1Px;
    logic s1ColOk;
    logic [NUM_OBJ-1:0] hit;
    logic [2:0] winIdx;

    assign xDiff = {1'b0, iPix_x} - 11'(X_ORIGIN);
    assign xCol  = xDiff[9:0] >> TILE_SHIFT;

    for (genvar g = 0; g < NUM_OBJ; g++) begin : gHit
        assign hit[g] = active[g].valid && (active[g].x == s1Col) && s1ColOk;
    end

    always_comb begin
        winIdx = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--)
            if (hit[i]) winIdx = 3'(i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vldPipe  <= '0;
            s1Col    <= '0;
            s1Px     <= '0;
            s1ColOk  <= 1'b0;
            oObj_hit <= 1'b0;
            oTile_no <= '0;
            oTile_px <= '0;
            oTile_py <= '0;
        end else begin
            vldPipe <= {vldPipe[0], iPix_valid};
            s1Col   <= xCol[4:0];
            s1Px    <= xDiff[4:0];
            s1ColOk <= !xDiff[10] && (xCol <= 10'(MAX_COL));
            if (vldPipe[0] && |hit) begin
                oObj_hit <= 1'b1;
                oTile_no <= active[winIdx].tile;
                oTile_px <= s1Px;
                oTile_py <= pyActive;
            end else begin
                oObj_hit <= 1'b0;
                oTile_no <= '0;
                oTile_px <= '0;
                oTile_py <= '0;
            end
        end
    end

    assign oPix_valid = vldPipe[1];

`ifdef OBJ_COLLIDE_EN
    logic vsPrev, multiHit;
    // clearing the lowest set bit leaves a non-zero vector only with 2+ hits
    assign multiHit = |(hit & (hit - NUM_OBJ'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsPrev   <= 1'b0;
            oCollide <= 1'b0;
        end else begin
            vsPrev <= iVS;
            if (vldPipe[0] && multiHit) oCollide <= 1'b1;
            else if (vsPrev && !iVS)    oCollide <= 1'b0;
        end
    end
`else
    logic unusedVs;
    assign unusedVs = iVS;
`endif
endmodule

// File: tb/tb_obj_scan_renderer.sv
// Directed bench for obj_scan_renderer; second instance uses Y_ORIGIN=8.
module tb_obj_scan_renderer;
    logic clk, reset_n;
    logic [2:0] wAddr;
    logic [12:0] wData;
    logic we, vs, lineStart, pixValid;
    logic [9:0] nextY, pixX;
    logic pv, hit, busy, pv2, hit2, busy2;
    logic [2:0] tno, tno2;
    logic [4:0] tpx, tpy, tpx2, tpy2;
`ifdef OBJ_COLLIDE_EN
    logic coll, coll2;
`endif
    int nChecks = 0;
    int nFail = 0;

    obj_scan_renderer uDut (
        .clk(clk), .reset_n(reset_n), .iObjRam_addr(wAddr), .iObjRam_data(wData),
        .iObjRam_we(we), .iVS(vs), .iLine_start(lineStart), .iNext_y(nextY),
        .iPix_valid(pixValid), .iPix_x(pixX), .oPix_valid(pv), .oObj_hit(hit),
        .oTile_no(tno), .oTile_px(tpx), .oTile_py(tpy), .oScan_busy(busy)
`ifdef OBJ_COLLIDE_EN
        , .oCollide(coll)
`endif
    );

    obj_scan_renderer #(.Y_ORIGIN(8)) uDutY8 (
        .clk(clk), .reset_n(reset_n), .iObjRam_addr(wAddr), .iObjRam_data(wData),
        .iObjRam_we(we), .iVS(vs), .iLine_start(lineStart), .iNext_y(nextY),
        .iPix_valid(pixValid), .iPix_x(pixX), .oPix_valid(pv2), .oObj_hit(hit2),
        .oTile_no(tno2), .oTile_px(tpx2), .oTile_py(tpy2), .oScan_busy(busy2)
`ifdef OBJ_COLLIDE_EN
        , .oCollide(coll2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        wAddr = 3'(a); wData = 13'(d); we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic scan(input int y);
        int cnt;
        lineStart = 1'b1; nextY = 10'(y);
        tick();
        lineStart = 1'b0;
        cnt = 0;
        while (busy && cnt < 40) begin cnt++; tick(); end
        check($sformatf("busy_cycles_y%0d", y), cnt, 10);
    endtask

    task automatic pix(input int x, input int eHit, input int eTile, input int ePx, input int ePy);
        pixValid = 1'b1; pixX = 10'(x);
        tick();
        pixValid = 1'b0;
        tick();
        check($sformatf("pv_x%0d", x), pv, 1);
        check($sformatf("hit_x%0d", x), hit, eHit);
        check($sformatf("tile_x%0d", x), tno, eTile);
        check($sformatf("px_x%0d", x), tpx, ePx);
        check($sformatf("py_x%0d", x), tpy, ePy);
    endtask

    initial begin
        bit prev, vin;
        int cnt;
        reset_n = 1'b0;
        wAddr = '0; wData = '0; we = 0; vs = 0; lineStart = 0; nextY = '0; pixValid = 0; pixX = '0;
        tick(); tick();
        check("rst_pv", pv, 0);
        check("rst_hit", hit, 0);
        check("rst_tile", tno, 0);
        check("rst_px", tpx, 0);
        check("rst_py", tpy, 0);
        check("rst_busy", busy, 0);
`ifdef OBJ_COLLIDE_EN
        check("rst_coll", coll, 0);
`endif
        reset_n = 1'b1;
        tick();

        // empty RAM: no hits anywhere, valid delayed by 2
        scan(40);
        prev = 0;
        for (int x = 0; x < 640; x++) begin
            vin = ((x % 7) != 3);
            pixValid = vin; pixX = 10'(x);
            tick();
            check("sweep_pv", pv, int'(prev));
            check("sweep_hit", hit, 0);
            prev = vin;
        end
        pixValid = 0;
        tick();
        check("sweep_pv_last", pv, int'(prev));
        tick();

        // single object x1 y1
        wr(0, 13'h1011);
        scan(40);
        for (int x = 47; x <= 80; x++) begin
            if (x >= 48 && x <= 79) pix(x, 1, 0, x - 48, 8);
            else                    pix(x, 0, 0, 0, 0);
        end
`ifdef OBJ_COLLIDE_EN
        check("coll_single", coll, 0);
`endif

        // two objects on the same tile: lowest index wins
        wr(0, 13'h1052);
        wr(3, 13'h1252);
        scan(64);
        pix(176, 1, 0, 0, 0);
`ifdef OBJ_COLLIDE_EN
        check("coll_set", coll, 1);
        tick(); tick(); tick();
        check("coll_hold", coll, 1);
        vs = 1'b1; tick();
        check("coll_vs_high", coll, 1);
        vs = 1'b0; tick();
        check("coll_clr", coll, 0);
`endif
        wr(0, 0);
        scan(64);
        pix(176, 1, 1, 0, 0);
        wr(3, 0);

        // bottom-right tile and row/column limits
        wr(7, 13'h1F2E);
        scan(479);
        pix(591, 0, 0, 0, 0);
        pix(592, 1, 7, 0, 31);
        pix(623, 1, 7, 31, 31);
        pix(624, 0, 0, 0, 0);
        wr(1, 13'h1010);
        scan(5);
        pix(48, 1, 0, 0, 5);
        check("y8_pv", pv2, 1);
        check("y8_underflow_hit", hit2, 0);
        wr(2, 13'h102F);
        scan(480);
        pix(80, 0, 0, 0, 0);
        pix(592, 0, 0, 0, 0);

        // restart mid-scan: only the second line is committed
        wr(0, 13'h1011);
        wr(4, 13'h1032);
        lineStart = 1; nextY = 10'd40;
        tick();
        lineStart = 0;
        cnt = 0;
        repeat (3) begin if (busy) cnt++; tick(); end
        if (busy) cnt++;
        lineStart = 1; nextY = 10'd72;
        tick();
        lineStart = 0;
        while (busy && cnt < 60) begin cnt++; tick(); end
        check("restart_busy_cycles", cnt, 14);
        pix(112, 1, 0, 0, 8);
        pix(48, 0, 0, 0, 0);

        // reset in the middle of a scan
        pixValid = 1; pixX = 10'd112;
        lineStart = 1; nextY = 10'd40;
        tick();
        lineStart = 0;
        tick(); tick();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_hit", hit, 1);
        reset_n = 0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_hit", hit, 0);
        check("mid_rst_pv", pv, 0);
        check("mid_rst_py", tpy, 0);
        pixValid = 0;
        tick();
        reset_n = 1;
        tick();
        scan(72);
        pix(112, 0, 0, 0, 0);
        scan(40);
        pix(48, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
